writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage (MEM/WB) of the 32-bit MIPS-style core; sits directly upstream of the register file write port.
- Registers one retiring instruction and selects its result: ALU result, formatted load data, or link address.
- Waits for late load data through a small FSM, then drives write_en / write_reg_addr / write_data for exactly one cycle per retired instruction.
- Outputs are posedge-registered so the register file's negedge write samples stable values.

Parameters:
DATA_W, 32 (`ISA_WIDTH), datapath width
ADDR_W, 5 (`REG_FILE_ADDR_WIDTH), register address width
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, posedge
rst_n  in  1  asynchronous reset, active-low
flush  in  1  discard a not-yet-committed entry
in_valid  in  1  upstream presents an instruction
in_ready  out  1  stage can accept this cycle
in_reg_write  in  1  instruction writes a register
in_dest_addr  in  ADDR_W  destination register
in_wb_sel  in  2  00 ALU, 01 MEM, 10 LINK, 11 reserved (treated as ALU)
in_mem_size  in  2  00 byte, 01 half, 10 word
in_mem_unsigned  in  1  zero-extend the load (lbu/lhu)
in_addr_low  in  2  load address bits [1:0]
in_alu_result  in  DATA_W  ALU result
in_link_addr  in  DATA_W  return address for jal/jalr
in_mem_data  in  DATA_W  raw aligned memory word
in_mem_data_valid  in  1  in_mem_data is valid this cycle
write_en  out  1  register file write enable
write_reg_addr  out  ADDR_W  register file write address
write_data  out  DATA_W  register file write data
wb_valid  out  1  an instruction retires this cycle
misalign_err  out  1  one-cycle pulse: misaligned load dropped
retired_count  out  CNT_W  count of retired instructions

Behaviour:
- Reset (rst_n=0, async): state EMPTY; write_en=0, write_reg_addr=0, write_data=0, wb_valid=0, misalign_err=0, retired_count=0; in_ready=1 once reset releases.
- FSM states:
  - EMPTY: no retirement this cycle.
  - WAIT_MEM: holds a load whose data has not yet arrived.
  - COMMIT: outputs valid for one cycle.
- in_ready = (state != WAIT_MEM) && !flush.
- Accept = in_valid && in_ready.
- Transitions on accept:
  - wb_sel=MEM && !in_mem_data_valid -> WAIT_MEM; capture all fields except data.
  - Otherwise -> COMMIT with the result computed in the same cycle.
- WAIT_MEM:
  - in_mem_data_valid -> COMMIT with formatted data.
  - flush -> EMPTY; no write, no count increment.
  - Flush has priority over data arriving in the same cycle.
- COMMIT -> COMMIT on a back-to-back accept; otherwise -> EMPTY. Throughput is one instruction per cycle when load data is not late.
- Latency: accept edge -> outputs valid after the next posedge (1 cycle). Late loads add 1 cycle after in_mem_data_valid.
- In COMMIT:
  - wb_valid=1.
  - write_en = reg_write && dest!=0 && !misaligned.
  - write_reg_addr = dest; write_data = selected value.
  - When write_en=0, write_reg_addr and write_data hold their previous values.
- flush never cancels an entry already in COMMIT.
- Load formatting (little-endian):
  - byte: data[8*addr_low +: 8].
  - half: data[16*addr_low[1] +: 16].
  - word: whole word.
  - Sign- or zero-extend per in_mem_unsigned.
- Misaligned load: half with addr_low[0]=1, or word with addr_low!=0.
  - Still retires: wb_valid=1, retired_count increments.
  - write_en=0; misalign_err pulses in the COMMIT cycle.
- retired_count increments by 1 per COMMIT cycle, including non-writing instructions. It wraps modulo 2^CNT_W.
- Reset asserted mid-WAIT_MEM drops the entry immediately.

Optional Feature:
- Macro WB_FORWARD_EN.
- Defined: adds the following outputs for the EX-stage bypass and hazard unit:
  - fwd_valid (=write_en), fwd_addr, fwd_data (combinational copies of the registered write_* outputs).
  - fwd_busy (1 in WAIT_MEM with reg_write && dest!=0).
  - fwd_busy_addr (the pending dest; 0 when not busy).
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared definitions header gains:
  - WB_SEL_ALU/MEM/LINK codes.
  - MEM_SIZE_BYTE/HALF/WORD codes.
  - FSM state encodings WB_EMPTY/WB_WAIT_MEM/WB_COMMIT.
- Sub-module load_formatter: combinational; takes raw word, size, unsigned, addr_low; produces extended data and a misaligned flag.

Test Plan:
- ALU op (reg_write=1, dest=5, alu=0x1234_5678, wb_sel=00) -> next cycle: write_en=1, addr=5, data=0x12345678, retired_count=1.
- lb with mem_data=0x80FF_7F01, addr_low=3, signed -> data=0xFFFF_FF80; same with lbu -> 0x0000_0080.
- Load with data_valid low for 3 cycles, then high with 0xDEAD_BEEF (word) -> in_ready=0 during the wait; write 0xDEADBEEF one cycle after data; exactly one write.
- Flush while in WAIT_MEM (dest=9) -> no write, retired_count unchanged, in_ready=1 next cycle.
- Writes to dest=0, and lh with addr_low=1 -> wb_valid=1, write_en=0; misalign_err pulses only for the lh.
- Back-to-back accepts of 4 ALU ops (dests 1..4) -> 4 consecutive write_en cycles, retired_count=4.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the MEM/WB writeback stage: result-select and load-size codes,
// FSM state encoding and the load alignment rule.
package writeback_stage_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    WB_EMPTY    = 2'd0,
    WB_WAIT_MEM = 2'd1,
    WB_COMMIT   = 2'd2
  } wb_state_e;

  // Reserved size code 11 is aligned like a word.
  function automatic logic load_misaligned(input logic [1:0] size, input logic [1:0] addr_low);
    logic mis;
    unique case (size)
      MEM_SIZE_BYTE: mis = 1'b0;
      MEM_SIZE_HALF: mis = addr_low[0];
      default:       mis = (addr_low != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Upstream instruction bus and register-file write bus of the writeback stage.
// Forwarding signals exist only when WB_FORWARD_EN is defined.
interface writeback_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_reg_write;
  logic [ADDR_W-1:0] in_dest_addr;
  logic [1:0]        in_wb_sel;
  logic [1:0]        in_mem_size;
  logic              in_mem_unsigned;
  logic [1:0]        in_addr_low;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_link_addr;
  logic [DATA_W-1:0] in_mem_data;
  logic              in_mem_data_valid;

  logic              write_en;
  logic [ADDR_W-1:0] write_reg_addr;
  logic [DATA_W-1:0] write_data;
  logic              wb_valid;
  logic              misalign_err;
  logic [CNT_W-1:0]  retired_count;

`ifdef WB_FORWARD_EN
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
  logic              fwd_busy;
  logic [ADDR_W-1:0] fwd_busy_addr;
`endif

  modport master (
    output flush, in_valid, in_reg_write, in_dest_addr, in_wb_sel, in_mem_size,
           in_mem_unsigned, in_addr_low, in_alu_result, in_link_addr, in_mem_data,
           in_mem_data_valid,
`ifdef WB_FORWARD_EN
    input  fwd_valid, fwd_addr, fwd_data, fwd_busy, fwd_busy_addr,
`endif
    input  in_ready, write_en, write_reg_addr, write_data, wb_valid, misalign_err,
           retired_count
  );

  modport slave (
    input  flush, in_valid, in_reg_write, in_dest_addr, in_wb_sel, in_mem_size,
           in_mem_unsigned, in_addr_low, in_alu_result, in_link_addr, in_mem_data,
           in_mem_data_valid,
`ifdef WB_FORWARD_EN
    output fwd_valid, fwd_addr, fwd_data, fwd_busy, fwd_busy_addr,
`endif
    output in_ready, write_en, write_reg_addr, write_data, wb_valid, misalign_err,
           retired_count
  );

endinterface

// File: rtl/writeback_stage_load_formatter.sv
// Little-endian load extraction with sign/zero extension, plus misalignment detection.
module writeback_stage_load_formatter
  import writeback_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        size_i,
  input  logic              zero_ext_i,
  input  logic [1:0]        addr_low_i,
  output logic [DATA_W-1:0] data_o,
  output logic              misaligned_o
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = data_i[8*addr_low_i +: 8];
    half_val = data_i[16*addr_low_i[1] +: 16];
    unique case (size_i)
      MEM_SIZE_BYTE: data_o = {{(DATA_W-8){byte_val[7] & ~zero_ext_i}}, byte_val};
      MEM_SIZE_HALF: data_o = {{(DATA_W-16){half_val[15] & ~zero_ext_i}}, half_val};
      default:       data_o = data_i;
    endcase
    misaligned_o = load_misaligned(size_i, addr_low_i);
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB stage: registers one retiring instruction, waits for late load data, and drives the
// register-file write port for one cycle per retirement. Optional bypass ports: WB_FORWARD_EN.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input logic               clk,
  input logic               rst_n,
  writeback_stage_if.slave  bus
);

  wb_state_e         state_q, state_d;

  logic              pend_reg_write_q, pend_reg_write_d;
  logic [ADDR_W-1:0] pend_dest_q, pend_dest_d;
  logic [1:0]        pend_size_q, pend_size_d;
  logic              pend_unsigned_q, pend_unsigned_d;
  logic [1:0]        pend_addr_low_q, pend_addr_low_d;

  logic              write_en_q, write_en_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              wb_valid_q, wb_valid_d;
  logic              misalign_q, misalign_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              waiting;
  logic              in_ready;
  logic              accept;
  logic [1:0]        fmt_size;
  logic              fmt_unsigned;
  logic [1:0]        fmt_addr_low;
  logic [DATA_W-1:0] fmt_data;
  logic              fmt_misaligned;

  logic              commit;
  logic              c_reg_write;
  logic [ADDR_W-1:0] c_dest;
  logic              c_is_mem;
  logic [DATA_W-1:0] c_value;

  assign waiting  = (state_q == WB_WAIT_MEM);
  assign in_ready = !waiting && !bus.flush;
  assign accept   = bus.in_valid && in_ready;

  // A pending load formats with its captured controls; otherwise the incoming ones apply.
  assign fmt_size     = waiting ? pend_size_q     : bus.in_mem_size;
  assign fmt_unsigned = waiting ? pend_unsigned_q : bus.in_mem_unsigned;
  assign fmt_addr_low = waiting ? pend_addr_low_q : bus.in_addr_low;

  writeback_stage_load_formatter #(
    .DATA_W (DATA_W)
  ) u_load_formatter (
    .data_i       (bus.in_mem_data),
    .size_i       (fmt_size),
    .zero_ext_i   (fmt_unsigned),
    .addr_low_i   (fmt_addr_low),
    .data_o       (fmt_data),
    .misaligned_o (fmt_misaligned)
  );

  always_comb begin
    state_d          = state_q;
    pend_reg_write_d = pend_reg_write_q;
    pend_dest_d      = pend_dest_q;
    pend_size_d      = pend_size_q;
    pend_unsigned_d  = pend_unsigned_q;
    pend_addr_low_d  = pend_addr_low_q;
    commit           = 1'b0;
    c_reg_write      = 1'b0;
    c_dest           = '0;
    c_is_mem         = 1'b0;
    c_value          = '0;

    unique case (state_q)
      WB_WAIT_MEM: begin
        // Flush wins over data arriving in the same cycle.
        if (bus.flush) begin
          state_d = WB_EMPTY;
        end else if (bus.in_mem_data_valid) begin
          state_d     = WB_COMMIT;
          commit      = 1'b1;
          c_reg_write = pend_reg_write_q;
          c_dest      = pend_dest_q;
          c_is_mem    = 1'b1;
          c_value     = fmt_data;
        end
      end
      default: begin
        if (!accept) begin
          state_d = WB_EMPTY;
        end else if (bus.in_wb_sel == WB_SEL_MEM && !bus.in_mem_data_valid) begin
          state_d          = WB_WAIT_MEM;
          pend_reg_write_d = bus.in_reg_write;
          pend_dest_d      = bus.in_dest_addr;
          pend_size_d      = bus.in_mem_size;
          pend_unsigned_d  = bus.in_mem_unsigned;
          pend_addr_low_d  = bus.in_addr_low;
        end else begin
          state_d     = WB_COMMIT;
          commit      = 1'b1;
          c_reg_write = bus.in_reg_write;
          c_dest      = bus.in_dest_addr;
          c_is_mem    = (bus.in_wb_sel == WB_SEL_MEM);
          unique case (bus.in_wb_sel)
            WB_SEL_MEM:  c_value = fmt_data;
            WB_SEL_LINK: c_value = bus.in_link_addr;
            default:     c_value = bus.in_alu_result;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    write_en_d   = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    wb_valid_d   = 1'b0;
    misalign_d   = 1'b0;
    count_d      = count_q;
    if (commit) begin
      wb_valid_d = 1'b1;
      misalign_d = c_is_mem && fmt_misaligned;
      write_en_d = c_reg_write && (c_dest != '0) && !misalign_d;
      count_d    = count_q + CNT_W'(1);
      if (write_en_d) begin
        write_addr_d = c_dest;
        write_data_d = c_value;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= WB_EMPTY;
      pend_reg_write_q <= 1'b0;
      pend_dest_q      <= '0;
      pend_size_q      <= MEM_SIZE_BYTE;
      pend_unsigned_q  <= 1'b0;
      pend_addr_low_q  <= 2'b00;
      write_en_q       <= 1'b0;
      write_addr_q     <= '0;
      write_data_q     <= '0;
      wb_valid_q       <= 1'b0;
      misalign_q       <= 1'b0;
      count_q          <= '0;
    end else begin
      state_q          <= state_d;
      pend_reg_write_q <= pend_reg_write_d;
      pend_dest_q      <= pend_dest_d;
      pend_size_q      <= pend_size_d;
      pend_unsigned_q  <= pend_unsigned_d;
      pend_addr_low_q  <= pend_addr_low_d;
      write_en_q       <= write_en_d;
      write_addr_q     <= write_addr_d;
      write_data_q     <= write_data_d;
      wb_valid_q       <= wb_valid_d;
      misalign_q       <= misalign_d;
      count_q          <= count_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.write_en       = write_en_q;
  assign bus.write_reg_addr = write_addr_q;
  assign bus.write_data     = write_data_q;
  assign bus.wb_valid       = wb_valid_q;
  assign bus.misalign_err   = misalign_q;
  assign bus.retired_count  = count_q;

`ifdef WB_FORWARD_EN
  logic fwd_busy;
  assign fwd_busy          = waiting && pend_reg_write_q && (pend_dest_q != '0);
  assign bus.fwd_valid     = write_en_q;
  assign bus.fwd_addr      = write_addr_q;
  assign bus.fwd_data      = write_data_q;
  assign bus.fwd_busy      = fwd_busy;
  assign bus.fwd_busy_addr = fwd_busy ? pend_dest_q : '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: a behavioural retirement model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_writeback_stage;

  logic clk;
  logic rst_n;

  writeback_stage_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus ();

  writeback_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  bit          m_pending;
  bit          m_rw;
  logic [4:0]  m_dest;
  logic [1:0]  m_size;
  bit          m_uns;
  logic [1:0]  m_alow;
  bit          e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  bit          e_wbv;
  bit          e_mis;
  logic [31:0] e_cnt;

  function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [1:0] size,
                                           input bit uns, input logic [1:0] alow);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (d >> (8 * alow)) & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (d >> (16 * alow[1])) & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic bit bad_align(input logic [1:0] size, input logic [1:0] alow);
    if (size == 2'd0) return 1'b0;
    if (size == 2'd1) return alow[0];
    return alow != 2'd0;
  endfunction

  task automatic m_reset();
    m_pending = 0; m_rw = 0; m_dest = '0; m_size = '0; m_uns = 0; m_alow = '0;
    e_we = 0; e_addr = '0; e_data = '0; e_wbv = 0; e_mis = 0; e_cnt = '0;
  endtask

  task automatic m_retire(input bit rw, input logic [4:0] dest, input bit mis,
                          input logic [31:0] value);
    e_wbv = 1;
    e_mis = mis;
    e_we  = rw && dest != 0 && !mis;
    if (e_we) begin
      e_addr = dest;
      e_data = value;
    end
    e_cnt = e_cnt + 1;
  endtask

  task automatic m_step();
    logic [31:0] v;
    e_wbv = 0; e_we = 0; e_mis = 0;
    if (m_pending) begin
      if (bus.flush) m_pending = 0;
      else if (bus.in_mem_data_valid) begin
        m_pending = 0;
        m_retire(m_rw, m_dest, bad_align(m_size, m_alow),
                 fmt_load(bus.in_mem_data, m_size, m_uns, m_alow));
      end
    end else if (bus.in_valid && !bus.flush) begin
      if (bus.in_wb_sel == 2'd1 && !bus.in_mem_data_valid) begin
        m_pending = 1;
        m_rw = bus.in_reg_write; m_dest = bus.in_dest_addr; m_size = bus.in_mem_size;
        m_uns = bus.in_mem_unsigned; m_alow = bus.in_addr_low;
      end else if (bus.in_wb_sel == 2'd1) begin
        v = fmt_load(bus.in_mem_data, bus.in_mem_size, bus.in_mem_unsigned, bus.in_addr_low);
        m_retire(bus.in_reg_write, bus.in_dest_addr,
                 bad_align(bus.in_mem_size, bus.in_addr_low), v);
      end else begin
        v = (bus.in_wb_sel == 2'd2) ? bus.in_link_addr : bus.in_alu_result;
        m_retire(bus.in_reg_write, bus.in_dest_addr, 1'b0, v);
      end
    end
  endtask

  always @(negedge rst_n) m_reset();

  // Per-cycle compare against the model, 1 time unit after the active edge.
  always @(posedge clk) begin
    if (!rst_n) m_reset();
    else m_step();
    #1;
    check("cmp_write_en", {31'd0, bus.write_en}, {31'd0, e_we});
    check("cmp_write_addr", {27'd0, bus.write_reg_addr}, {27'd0, e_addr});
    check("cmp_write_data", bus.write_data, e_data);
    check("cmp_wb_valid", {31'd0, bus.wb_valid}, {31'd0, e_wbv});
    check("cmp_misalign", {31'd0, bus.misalign_err}, {31'd0, e_mis});
    check("cmp_count", bus.retired_count, e_cnt);
    check("cmp_in_ready", {31'd0, bus.in_ready}, {31'd0, !m_pending && !bus.flush});
  end

  task automatic idle();
    bus.flush = 0; bus.in_valid = 0; bus.in_reg_write = 0; bus.in_dest_addr = '0;
    bus.in_wb_sel = '0; bus.in_mem_size = '0; bus.in_mem_unsigned = 0; bus.in_addr_low = '0;
    bus.in_alu_result = '0; bus.in_link_addr = '0; bus.in_mem_data = '0;
    bus.in_mem_data_valid = 0;
  endtask

  task automatic drive(input logic [4:0] dest, input logic [1:0] sel, input logic [1:0] size,
                       input bit uns, input logic [1:0] alow, input logic [31:0] alu,
                       input logic [31:0] link, input logic [31:0] mdata, input bit dv);
    bus.in_valid = 1; bus.in_reg_write = 1; bus.in_dest_addr = dest; bus.in_wb_sel = sel;
    bus.in_mem_size = size; bus.in_mem_unsigned = uns; bus.in_addr_low = alow;
    bus.in_alu_result = alu; bus.in_link_addr = link; bus.in_mem_data = mdata;
    bus.in_mem_data_valid = dv;
  endtask

  task automatic expect_out(input string tag, input bit we, input logic [4:0] addr,
                            input logic [31:0] data, input bit wbv, input bit mis,
                            input logic [31:0] cnt);
    check({tag, "_we"}, {31'd0, bus.write_en}, {31'd0, we});
    check({tag, "_addr"}, {27'd0, bus.write_reg_addr}, {27'd0, addr});
    check({tag, "_data"}, bus.write_data, data);
    check({tag, "_wbv"}, {31'd0, bus.wb_valid}, {31'd0, wbv});
    check({tag, "_mis"}, {31'd0, bus.misalign_err}, {31'd0, mis});
    check({tag, "_cnt"}, bus.retired_count, cnt);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_reset();
    rst_n = 0;
    idle();
    repeat (2) @(negedge clk);
    expect_out("reset", 0, 5'd0, 32'h0, 0, 0, 32'd0);
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst_n = 1;
    @(negedge clk);

    // ALU op
    drive(5'd5, 2'b00, 2'd2, 0, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 0);
    @(negedge clk); idle();
    expect_out("alu", 1, 5'd5, 32'h1234_5678, 1, 0, 32'd1);

    // lb / lbu from byte 3
    drive(5'd6, 2'b01, 2'd0, 0, 2'd3, 32'h0, 32'h0, 32'h80FF_7F01, 1);
    @(negedge clk); idle();
    expect_out("lb", 1, 5'd6, 32'hFFFF_FF80, 1, 0, 32'd2);
    drive(5'd6, 2'b01, 2'd0, 1, 2'd3, 32'h0, 32'h0, 32'h80FF_7F01, 1);
    @(negedge clk); idle();
    expect_out("lbu", 1, 5'd6, 32'h0000_0080, 1, 0, 32'd3);

    // Late word load: data low for 3 cycles
    drive(5'd7, 2'b01, 2'd2, 0, 2'd0, 32'h0, 32'h0, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle();
      check("late_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("late_no_write", {31'd0, bus.write_en}, 32'd0);
    end
    bus.in_mem_data = 32'hDEAD_BEEF; bus.in_mem_data_valid = 1;
    @(negedge clk); idle();
    expect_out("late", 1, 5'd7, 32'hDEAD_BEEF, 1, 0, 32'd4);
    @(negedge clk);
    check("late_single_write", {31'd0, bus.write_en}, 32'd0);

    // Flush in WAIT_MEM, with data arriving in the same cycle
    drive(5'd9, 2'b01, 2'd2, 0, 2'd0, 32'h0, 32'h0, 32'h0, 0);
    @(negedge clk); idle();
    bus.flush = 1; bus.in_mem_data = 32'h5555_AAAA; bus.in_mem_data_valid = 1;
    @(negedge clk); idle();
    expect_out("flush", 0, 5'd7, 32'hDEAD_BEEF, 0, 0, 32'd4);
    #1 check("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);

    // dest 0 and misaligned lh
    drive(5'd0, 2'b00, 2'd2, 0, 2'd0, 32'hCAFE_0000, 32'h0, 32'h0, 0);
    @(negedge clk); idle();
    expect_out("dest0", 0, 5'd7, 32'hDEAD_BEEF, 1, 0, 32'd5);
    drive(5'd8, 2'b01, 2'd1, 0, 2'd1, 32'h0, 32'h0, 32'h1234_5678, 1);
    @(negedge clk); idle();
    expect_out("lh_mis", 0, 5'd7, 32'hDEAD_BEEF, 1, 1, 32'd6);

    // LINK select, then reserved select behaving as ALU
    drive(5'd10, 2'b10, 2'd2, 0, 2'd0, 32'h1111_1111, 32'h0040_0010, 32'h0, 0);
    @(negedge clk); idle();
    expect_out("link", 1, 5'd10, 32'h0040_0010, 1, 0, 32'd7);
    drive(5'd11, 2'b11, 2'd2, 0, 2'd0, 32'hA5A5_A5A5, 32'h0040_0020, 32'h0, 0);
    @(negedge clk); idle();
    expect_out("rsvd", 1, 5'd11, 32'hA5A5_A5A5, 1, 0, 32'd8);

    // Signed halfword from upper half
    drive(5'd12, 2'b01, 2'd1, 0, 2'd2, 32'h0, 32'h0, 32'h8001_7FFF, 1);
    @(negedge clk); idle();
    expect_out("lh_hi", 1, 5'd12, 32'hFFFF_8001, 1, 0, 32'd9);

    // Back-to-back ALU ops, dests 1..4
    for (int i = 1; i <= 4; i++) begin
      drive(5'(i), 2'b00, 2'd2, 0, 2'd0, 32'(i) * 32'h11, 32'h0, 32'h0, 0);
      @(negedge clk);
      expect_out("b2b", 1, 5'(i), 32'(i) * 32'h11, 1, 0, 32'd9 + 32'(i));
    end
    idle();
    @(negedge clk);

    // Reset while a load waits: entry is dropped
    drive(5'd13, 2'b01, 2'd2, 0, 2'd0, 32'h0, 32'h0, 32'h0, 0);
    @(negedge clk); idle();
    #2 rst_n = 0;
    #1 expect_out("rst_mid", 0, 5'd0, 32'h0, 0, 0, 32'd0);
    @(negedge clk);
    rst_n = 1;
    bus.in_mem_data = 32'h7777_7777; bus.in_mem_data_valid = 1;
    @(negedge clk); idle();
    expect_out("rst_drop", 0, 5'd0, 32'h0, 0, 0, 32'd0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
